// File: rtl/adc_pulse_detector.sv
// adc_pulse_detector: moving-average filter over 12-bit ADC samples feeding a
// hysteresis pulse detector (enter at thr_hi, leave below thr_lo) that reports
// each completed pulse's peak, width and a running event count.
// Ports: clk_100/reset_n (async active-low); en, sample_valid, sample_data,
//   thr_hi, thr_lo in; avg_valid/avg_data (1 cycle after an accepted sample),
//   pulse_active, event_valid/event_peak/event_width, event_count out.
// Accepts one sample per cycle with no backpressure; en=0 aborts and refills.
module adc_pulse_detector #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk_100,
  input  logic        reset_n,
  input  logic        en,
  input  logic        sample_valid,
  input  logic [11:0] sample_data,
  input  logic [11:0] thr_hi,
  input  logic [11:0] thr_lo,
  output logic        avg_valid,
  output logic [11:0] avg_data,
  output logic        pulse_active,
  output logic        event_valid,
  output logic [11:0] event_peak,
  output logic [15:0] event_width,
  output logic [15:0] event_count
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = 12 + AVG_LOG2;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_IDLE  = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [11:0]         hist_q [DEPTH];
  logic [11:0]         hist_d [DEPTH];
  logic [SUM_W-1:0]    sum_q, sum_d, sum_next;
  logic [AVG_LOG2:0]   fill_cnt_q, fill_cnt_d;
  logic                avg_valid_q, avg_valid_d;
  logic [11:0]         avg_data_q, avg_data_d;
  logic                pulse_active_q, pulse_active_d;
  logic [11:0]         peak_q, peak_d;
  logic [15:0]         width_q, width_d;
  logic                event_valid_q, event_valid_d;
  logic [11:0]         event_peak_q, event_peak_d;
  logic [15:0]         event_width_q, event_width_d;
  logic [15:0]         event_count_q, event_count_d;
  logic                accept;

  assign accept = sample_valid & en;

  // hist_q[DEPTH-1] is the oldest sample; it leaves the window as the new one enters.
  assign sum_next = sum_q + SUM_W'(sample_data) - SUM_W'(hist_q[DEPTH-1]);

  always_comb begin
    state_d       = state_q;
    hist_d        = hist_q;
    sum_d         = sum_q;
    fill_cnt_d    = fill_cnt_q;
    avg_valid_d   = 1'b0;
    avg_data_d    = avg_data_q;
    peak_d        = peak_q;
    width_d       = width_q;
    event_valid_d = 1'b0;
    event_peak_d  = event_peak_q;
    event_width_d = event_width_q;
    event_count_d = event_count_q;

    if (!en) begin
      // Abort: drop any pulse silently and refill the averaging window.
      state_d    = S_FILL;
      sum_d      = '0;
      fill_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
    end else begin
      // Detector reacts to the registered average, so thresholds sampled here
      // apply to the next avg_valid only.
      if (avg_valid_q) begin
        case (state_q)
          S_IDLE: begin
            if (avg_data_q >= thr_hi) begin
              state_d = S_PULSE;
              peak_d  = avg_data_q;
              width_d = 16'd1;
            end
          end
          S_PULSE: begin
            if (avg_data_q >= thr_lo) begin
              if (width_q != 16'hFFFF) width_d = width_q + 16'd1;
              if (avg_data_q > peak_q) peak_d = avg_data_q;
            end else begin
              state_d       = S_IDLE;
              event_valid_d = 1'b1;
              event_peak_d  = peak_q;
              event_width_d = width_q;
              event_count_d = event_count_q + 16'd1;
            end
          end
          default: ;
        endcase
      end

      if (accept) begin
        hist_d[0] = sample_data;
        for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
        sum_d = sum_next;
        if (state_q == S_FILL) begin
          if (fill_cnt_q == (AVG_LOG2+1)'(DEPTH - 1)) begin
            // Window just became full: first valid average goes out.
            state_d     = S_IDLE;
            avg_valid_d = 1'b1;
            avg_data_d  = 12'(sum_next >> AVG_LOG2);
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end else begin
          avg_valid_d = 1'b1;
          avg_data_d  = 12'(sum_next >> AVG_LOG2);
        end
      end
    end

    pulse_active_d = (state_d == S_PULSE);
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_FILL;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      sum_q          <= '0;
      fill_cnt_q     <= '0;
      avg_valid_q    <= 1'b0;
      avg_data_q     <= '0;
      pulse_active_q <= 1'b0;
      peak_q         <= '0;
      width_q        <= '0;
      event_valid_q  <= 1'b0;
      event_peak_q   <= '0;
      event_width_q  <= '0;
      event_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      hist_q         <= hist_d;
      sum_q          <= sum_d;
      fill_cnt_q     <= fill_cnt_d;
      avg_valid_q    <= avg_valid_d;
      avg_data_q     <= avg_data_d;
      pulse_active_q <= pulse_active_d;
      peak_q         <= peak_d;
      width_q        <= width_d;
      event_valid_q  <= event_valid_d;
      event_peak_q   <= event_peak_d;
      event_width_q  <= event_width_d;
      event_count_q  <= event_count_d;
    end
  end

  assign avg_valid    = avg_valid_q;
  assign avg_data     = avg_data_q;
  assign pulse_active = pulse_active_q;
  assign event_valid  = event_valid_q;
  assign event_peak   = event_peak_q;
  assign event_width  = event_width_q;
  assign event_count  = event_count_q;

endmodule

// File: tb/tb_adc_pulse_detector.sv
// tb_adc_pulse_detector: directed bench for adc_pulse_detector with two
// instances (AVG_LOG2=0 and AVG_LOG2=2) sharing one stimulus bus.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_adc_pulse_detector;

  logic        clk_100;
  logic        reset_n;
  logic        en;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic [11:0] thr_hi;
  logic [11:0] thr_lo;

  logic        a0_avg_valid, a2_avg_valid;
  logic [11:0] a0_avg_data, a2_avg_data;
  logic        a0_pulse_active, a2_pulse_active;
  logic        a0_event_valid, a2_event_valid;
  logic [11:0] a0_event_peak, a2_event_peak;
  logic [15:0] a0_event_width, a2_event_width;
  logic [15:0] a0_event_count, a2_event_count;

  int total;
  int bad;

  adc_pulse_detector #(.AVG_LOG2(0)) dut0 (
    .clk_100      (clk_100),
    .reset_n      (reset_n),
    .en           (en),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .thr_hi       (thr_hi),
    .thr_lo       (thr_lo),
    .avg_valid    (a0_avg_valid),
    .avg_data     (a0_avg_data),
    .pulse_active (a0_pulse_active),
    .event_valid  (a0_event_valid),
    .event_peak   (a0_event_peak),
    .event_width  (a0_event_width),
    .event_count  (a0_event_count)
  );

  adc_pulse_detector #(.AVG_LOG2(2)) dut2 (
    .clk_100      (clk_100),
    .reset_n      (reset_n),
    .en           (en),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .thr_hi       (thr_hi),
    .thr_lo       (thr_lo),
    .avg_valid    (a2_avg_valid),
    .avg_data     (a2_avg_data),
    .pulse_active (a2_pulse_active),
    .event_valid  (a2_event_valid),
    .event_peak   (a2_event_peak),
    .event_width  (a2_event_width),
    .event_count  (a2_event_count)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  task automatic cyc();
    @(posedge clk_100);
    #1;
  endtask

  task automatic push(input logic [11:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    cyc();
    sample_valid = 1'b0;
  endtask

  task automatic apply_reset(input logic [11:0] hi, input logic [11:0] lo);
    reset_n      = 1'b0;
    en           = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    thr_hi       = hi;
    thr_lo       = lo;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    logic [69:0] o0, o2;
    reset_n     = 1'b0;
    en          = 1'b1;
    sample_data = 12'hFFF;
    thr_hi      = 12'd0;
    thr_lo      = 12'd0;
    for (int i = 0; i < 6; i++) begin
      sample_valid = (i % 2 == 0);
      cyc();
      o0 = {a0_avg_valid, a0_avg_data, a0_pulse_active, a0_event_valid,
            a0_event_peak, a0_event_width, a0_event_count};
      o2 = {a2_avg_valid, a2_avg_data, a2_pulse_active, a2_event_valid,
            a2_event_peak, a2_event_width, a2_event_count};
      total++;
      if (o0 !== '0) begin bad++; $display("FAIL reset_outputs_a0 cyc=%0d got=%h want=0", i, o0); end
      total++;
      if (o2 !== '0) begin bad++; $display("FAIL reset_outputs_a2 cyc=%0d got=%h want=0", i, o2); end
    end
    sample_valid = 1'b0;
    reset_n = 1'b1;
    cyc();
    total++;
    if (a2_avg_valid !== 1'b0) begin bad++; $display("FAIL reset_release_avg_valid got=%b want=0", a2_avg_valid); end
  endtask

  task automatic test_fill_average();
    logic [11:0] exp_avg [4];
    exp_avg[0] = 12'd1024; exp_avg[1] = 12'd2048; exp_avg[2] = 12'd3072; exp_avg[3] = 12'd4095;
    apply_reset(12'hFFF, 12'hFFF);
    for (int i = 0; i < 3; i++) begin
      push(12'd0);
      total++;
      if (a2_avg_valid !== 1'b0) begin bad++; $display("FAIL fill_suppress s=%0d got=%b want=0", i, a2_avg_valid); end
    end
    push(12'd3);
    total++;
    if (a2_avg_valid !== 1'b1 || a2_avg_data !== 12'd0)
      begin bad++; $display("FAIL fill_first_avg got v=%b d=%0d want v=1 d=0", a2_avg_valid, a2_avg_data); end
    cyc();
    total++;
    if (a2_avg_valid !== 1'b0) begin bad++; $display("FAIL avg_strobe_width got=%b want=0", a2_avg_valid); end
    for (int i = 0; i < 4; i++) begin
      push(12'd4095);
      total++;
      if (a2_avg_valid !== 1'b1 || a2_avg_data !== exp_avg[i])
        begin bad++; $display("FAIL avg_4095 s=%0d got v=%b d=%0d want v=1 d=%0d", i, a2_avg_valid, a2_avg_data, exp_avg[i]); end
    end
  endtask

  task automatic test_basic_event();
    apply_reset(12'd1000, 12'd800);
    push(12'd500);
    total++;
    if (a0_avg_valid !== 1'b1 || a0_avg_data !== 12'd500)
      begin bad++; $display("FAIL basic_first_avg got v=%b d=%0d want v=1 d=500", a0_avg_valid, a0_avg_data); end
    push(12'd1200);
    total++;
    if (a0_pulse_active !== 1'b0) begin bad++; $display("FAIL basic_pulse_early got=%b want=0", a0_pulse_active); end
    push(12'd1500);
    total++;
    if (a0_pulse_active !== 1'b1) begin bad++; $display("FAIL basic_pulse_rise got=%b want=1", a0_pulse_active); end
    push(12'd900);
    push(12'd700);
    total++;
    if (a0_event_valid !== 1'b0 || a0_pulse_active !== 1'b1)
      begin bad++; $display("FAIL basic_before_exit got ev=%b pa=%b want ev=0 pa=1", a0_event_valid, a0_pulse_active); end
    cyc();
    total++;
    if (a0_event_valid !== 1'b1 || a0_event_peak !== 12'd1500 || a0_event_width !== 16'd3 || a0_event_count !== 16'd1)
      begin bad++; $display("FAIL basic_event got v=%b pk=%0d w=%0d c=%0d want v=1 pk=1500 w=3 c=1",
                            a0_event_valid, a0_event_peak, a0_event_width, a0_event_count); end
    total++;
    if (a0_pulse_active !== 1'b0) begin bad++; $display("FAIL basic_pulse_fall got=%b want=0", a0_pulse_active); end
    cyc();
    total++;
    if (a0_event_valid !== 1'b0 || a0_event_peak !== 12'd1500 || a0_event_width !== 16'd3)
      begin bad++; $display("FAIL basic_hold got v=%b pk=%0d w=%0d want v=0 pk=1500 w=3",
                            a0_event_valid, a0_event_peak, a0_event_width); end
  endtask

  task automatic test_hysteresis();
    logic [11:0] seq [5];
    int ev;
    logic [11:0] pk;
    logic [15:0] wd;
    seq[0] = 12'd1200; seq[1] = 12'd900; seq[2] = 12'd1100; seq[3] = 12'd700; seq[4] = 12'd0;
    ev = 0; pk = '0; wd = '0;
    apply_reset(12'd1000, 12'd800);
    for (int i = 0; i < 4; i++) begin
      push(seq[i]);
      if (a0_event_valid) begin ev++; pk = a0_event_peak; wd = a0_event_width; end
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (a0_event_valid) begin ev++; pk = a0_event_peak; wd = a0_event_width; end
    end
    total++;
    if (ev != 1) begin bad++; $display("FAIL hyst_event_count got=%0d want=1", ev); end
    total++;
    if (pk !== 12'd1200 || wd !== 16'd3)
      begin bad++; $display("FAIL hyst_event got pk=%0d w=%0d want pk=1200 w=3", pk, wd); end
  endtask

  task automatic test_threshold_edges();
    apply_reset(12'd1000, 12'd800);
    push(12'd999);
    push(12'd1000);
    total++;
    if (a0_pulse_active !== 1'b0) begin bad++; $display("FAIL edge_below_hi got=%b want=0", a0_pulse_active); end
    push(12'd800);
    total++;
    if (a0_pulse_active !== 1'b1) begin bad++; $display("FAIL edge_equal_hi got=%b want=1", a0_pulse_active); end
    push(12'd799);
    total++;
    if (a0_pulse_active !== 1'b1 || a0_event_valid !== 1'b0)
      begin bad++; $display("FAIL edge_equal_lo got pa=%b ev=%b want pa=1 ev=0", a0_pulse_active, a0_event_valid); end
    cyc();
    total++;
    if (a0_event_valid !== 1'b1 || a0_event_peak !== 12'd1000 || a0_event_width !== 16'd2)
      begin bad++; $display("FAIL edge_exit got v=%b pk=%0d w=%0d want v=1 pk=1000 w=2",
                            a0_event_valid, a0_event_peak, a0_event_width); end
  endtask

  task automatic test_inverted_thresholds();
    apply_reset(12'd1000, 12'd2000);
    push(12'd1500);
    push(12'd1500);
    total++;
    if (a0_pulse_active !== 1'b1 || a0_event_valid !== 1'b0)
      begin bad++; $display("FAIL inv_entry got pa=%b ev=%b want pa=1 ev=0", a0_pulse_active, a0_event_valid); end
    cyc();
    total++;
    if (a0_event_valid !== 1'b1 || a0_event_width !== 16'd1 || a0_event_peak !== 12'd1500)
      begin bad++; $display("FAIL inv_event got v=%b pk=%0d w=%0d want v=1 pk=1500 w=1",
                            a0_event_valid, a0_event_peak, a0_event_width); end
  endtask

  task automatic test_abort();
    apply_reset(12'd1000, 12'd800);
    for (int i = 0; i < 4; i++) push(12'd2000);
    total++;
    if (a2_avg_valid !== 1'b1 || a2_avg_data !== 12'd2000)
      begin bad++; $display("FAIL abort_fill_avg got v=%b d=%0d want v=1 d=2000", a2_avg_valid, a2_avg_data); end
    cyc();
    total++;
    if (a2_pulse_active !== 1'b1) begin bad++; $display("FAIL abort_pulse_on got=%b want=1", a2_pulse_active); end
    en = 1'b0;
    cyc();
    en = 1'b1;
    total++;
    if (a2_pulse_active !== 1'b0 || a2_event_valid !== 1'b0 || a2_event_count !== 16'd0)
      begin bad++; $display("FAIL abort_drop got pa=%b ev=%b c=%0d want pa=0 ev=0 c=0",
                            a2_pulse_active, a2_event_valid, a2_event_count); end
    for (int i = 0; i < 3; i++) begin
      push(12'd2000);
      total++;
      if (a2_avg_valid !== 1'b0 || a2_event_valid !== 1'b0)
        begin bad++; $display("FAIL abort_refill s=%0d got v=%b ev=%b want v=0 ev=0", i, a2_avg_valid, a2_event_valid); end
    end
    push(12'd2000);
    total++;
    if (a2_avg_valid !== 1'b1 || a2_avg_data !== 12'd2000 || a2_event_count !== 16'd0)
      begin bad++; $display("FAIL abort_refilled got v=%b d=%0d c=%0d want v=1 d=2000 c=0",
                            a2_avg_valid, a2_avg_data, a2_event_count); end
  endtask

  task automatic test_reset_mid_pulse();
    apply_reset(12'd1000, 12'd800);
    push(12'd1500);
    push(12'd1500);
    total++;
    if (a0_pulse_active !== 1'b1) begin bad++; $display("FAIL rmp_pulse_on got=%b want=1", a0_pulse_active); end
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    push(12'd100);
    cyc();
    cyc();
    total++;
    if (a0_event_valid !== 1'b0 || a0_event_count !== 16'd0 || a0_pulse_active !== 1'b0)
      begin bad++; $display("FAIL rmp_no_event got ev=%b c=%0d pa=%b want ev=0 c=0 pa=0",
                            a0_event_valid, a0_event_count, a0_pulse_active); end
  endtask

  task automatic test_width_saturation();
    apply_reset(12'd1000, 12'd800);
    for (int i = 0; i < 70000; i++) push(12'd2000);
    total++;
    if (a0_pulse_active !== 1'b1) begin bad++; $display("FAIL sat_pulse_held got=%b want=1", a0_pulse_active); end
    push(12'd0);
    cyc();
    total++;
    if (a0_event_valid !== 1'b1 || a0_event_width !== 16'hFFFF || a0_event_peak !== 12'd2000 || a0_event_count !== 16'd1)
      begin bad++; $display("FAIL sat_width got v=%b w=%h pk=%0d c=%0d want v=1 w=ffff pk=2000 c=1",
                            a0_event_valid, a0_event_width, a0_event_peak, a0_event_count); end
  endtask

  task automatic test_count_wrap();
    force dut0.event_count_q = 16'hFFFF;
    cyc();
    cyc();
    release dut0.event_count_q;
    cyc();
    total++;
    if (a0_event_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h want=ffff", a0_event_count); end
    push(12'd2000);
    push(12'd0);
    cyc();
    total++;
    if (a0_event_valid !== 1'b1 || a0_event_count !== 16'd0)
      begin bad++; $display("FAIL wrap_count got v=%b c=%h want v=1 c=0", a0_event_valid, a0_event_count); end
    cyc();
    total++;
    if (a0_event_valid !== 1'b0 || a0_event_count !== 16'd0)
      begin bad++; $display("FAIL wrap_hold got v=%b c=%h want v=0 c=0", a0_event_valid, a0_event_count); end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset_n      = 1'b0;
    en           = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    thr_hi       = '0;
    thr_lo       = '0;
    test_reset();
    test_fill_average();
    test_basic_event();
    test_hysteresis();
    test_threshold_edges();
    test_inverted_thresholds();
    test_abort();
    test_reset_mid_pulse();
    test_width_saturation();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_pulse_detector.md
ADC_PULSE_DETECTOR -- requirements
Module: adc_pulse_detector

Interface
REQ-001 Parameter AVG_LOG2, default 2: moving-average window is 2^AVG_LOG2 samples; legal range 0..4.
REQ-002 clk_100  input  1  system clock; all logic is on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  detector enable; low aborts any pulse in progress.
REQ-005 sample_valid  input  1  one-cycle strobe, one per ADC conversion; back-to-back cycles are legal.
REQ-006 sample_data  input  12  unsigned ADC code, taken as the low 12 bits of the ADC converter output.
REQ-007 thr_hi  input  12  pulse-entry threshold, unsigned.
REQ-008 thr_lo  input  12  pulse-exit threshold, unsigned.
REQ-009 avg_valid  output  1  one-cycle strobe marking a new averaged sample.
REQ-010 avg_data  output  12  averaged sample, unsigned.
REQ-011 pulse_active  output  1  high while the state is PULSE.
REQ-012 event_valid  output  1  one-cycle strobe; a completed pulse is reported on this cycle.
REQ-013 event_peak  output  12  maximum avg_data seen during the reported pulse.
REQ-014 event_width  output  16  number of averaged samples in the reported pulse.
REQ-015 event_count  output  16  count of completed events since reset.

Function
REQ-016 A sample shall be accepted only when sample_valid=1 and en=1; all other strobes are ignored.
REQ-017 The block shall keep a 2^AVG_LOG2-deep history of samples and a running sum of width 12+AVG_LOG2 bits.
- Sum update per accepted sample: sum + new - oldest. No overflow is possible at this width.
REQ-018 avg_data shall be sum >> AVG_LOG2 (truncation, no rounding), registered so avg_valid asserts exactly one cycle after the accepted sample.
REQ-019 States are FILL, IDLE and PULSE.
REQ-020 FILL: avg_valid is suppressed until 2^AVG_LOG2 samples have been accepted; on the last of these the state moves to IDLE and that sample's average is emitted.
REQ-021 IDLE -> PULSE on an avg_valid with avg_data >= thr_hi.
- On entry, peak := avg_data and width := 1.
REQ-022 PULSE, on each avg_valid with avg_data >= thr_lo:
- width += 1, saturating at 0xFFFF.
- peak := max(peak, avg_data).
REQ-023 PULSE, on an avg_valid with avg_data < thr_lo:
- state -> IDLE.
- On the same edge, event_valid := 1 for one cycle, event_peak := peak, event_width := width, event_count += 1 (wraps 0xFFFF -> 0).
- The exit sample is not counted in width or peak.
REQ-024 The exit test shall be applied only from PULSE and never on the entry sample. If thr_lo > thr_hi, the pulse still lasts at least one sample.
REQ-025 event_peak and event_width shall hold their values until the next event.
REQ-026 When en=0, from any state:
- state -> FILL, history and sum cleared, fill counter cleared.
- pulse_active := 0 on the next edge.
- No event is emitted and event_count is unchanged.
REQ-027 Threshold changes shall take effect on the next avg_valid; no output glitches.

Reset
REQ-028 While reset_n=0, all of the following shall be 0 and the state shall be FILL:
- avg_valid, avg_data, pulse_active, event_valid, event_peak, event_width, event_count.
- History, sum and fill counter.
REQ-029 Reset asserted mid-pulse shall discard the pulse, with no event emitted after release.

Verification
REQ-030 Reset check: hold reset_n=0 with sample_valid toggling -> every output stays 0; release -> state FILL.
REQ-031 Fill/average check (AVG_LOG2=2, en=1):
- Samples 0,0,0,3 -> single avg_valid after the 4th sample, avg_data=0.
- Then four samples of 4095 -> avg_data=4095 on the 4th.
REQ-032 Basic event (AVG_LOG2=0, thr_hi=1000, thr_lo=800):
- Samples 500,1200,1500,900,700 -> pulse_active rises after 1200.
- event_valid one cycle after the 700 average, with event_peak=1500, event_width=3, event_count=1.
REQ-033 Hysteresis (AVG_LOG2=0, same thresholds):
- Samples 1200,900,1100,700 -> exactly one event, peak=1200, width=3.
REQ-034 Abort (AVG_LOG2=2):
- Drop en for one cycle during PULSE -> no event_valid, event_count unchanged.
- avg_valid absent until 4 new samples are accepted.
REQ-035 Saturation and wrap:
- Hold a pulse for 70000 samples -> event_width=0xFFFF.
- Preload 65535 events -> the next event gives event_count=0.
